stage_judge: RTL and testbench
==============================

STAGE_JUDGE -- requirements
Module: stage_judge

Interface
REQ-001 Parameters (name, default, meaning): W 3 item/luck width; N 4 items per stage; BW 2 bonus width; LOWMAX 2 low-quality threshold; TMO 15 max idle cycles between items; CW clog2(2N+1) bad-count width.
REQ-002 clk  in  1  system clock, rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 start  in  1  begin stage evaluation (pulse).
REQ-005 pass_in  in  1  previous-stage pass, sampled at start.
REQ-006 bonus_in  in  BW  bonus credit, sampled at start.
REQ-007 item_valid  in  1  item present this cycle.
REQ-008 item  in  W  item quality score (0 = missing).
REQ-009 luck  in  W  luck value, sampled with each item.
REQ-010 busy  out  1  high while not IDLE.
REQ-011 done  out  1  one-cycle pulse, result valid.
REQ-012 pass_out  out  1  stage result, held until next accepted start.
REQ-013 timeout  out  1  result caused by idle timeout, held with pass_out.
REQ-014 bad_cnt  out  CW  accumulated weighted accidents, held with pass_out.

Function
REQ-015 FSM states IDLE, COLLECT, JUDGE, DONE; IDLE->COLLECT on start; COLLECT->JUDGE after N-th accepted item or idle timeout; JUDGE->DONE; DONE->IDLE, unconditionally, one cycle each.
REQ-016 start in IDLE: latch pass_in and bonus_in; clear index, bad_cnt, fail flag, idle counter, timeout, pass_out; start outside IDLE ignored.
REQ-017 COLLECT: item accepted every cycle item_valid=1; index k counts 0..N-1.
REQ-018 Accepted item==0: set fail flag, no accident evaluated.
REQ-019 Accepted item!=0: accident if (item XOR luck)==(k mod 2^W); weight 2 if item<=LOWMAX, else 1; bad_cnt += weight (max 2N, no overflow in CW).
REQ-020 Idle counter: cleared on each accepted item, increments on COLLECT cycles with item_valid=0; reaching TMO sets timeout and exits to JUDGE.
REQ-021 JUDGE: pass_out = latched pass_in AND NOT fail AND NOT timeout AND (bad_cnt<=1 OR zero-extended bonus >= bad_cnt).
REQ-022 Latency: last item accepted at edge t -> JUDGE cycle t+1 -> done=1 and pass_out valid during cycle t+2.
REQ-023 item_valid ignored outside COLLECT; items beyond N never accepted.
REQ-024 busy=1 in COLLECT, JUDGE, DONE; done=1 only in DONE.

Reset
REQ-025 rst=1 forces IDLE asynchronously from any state, including mid-COLLECT.
REQ-026 Reset values: busy=0, done=0, pass_out=0, timeout=0, bad_cnt=0, all internal counters/flags 0.

Configuration
REQ-027 Macro STAGE_LFSR_EN defined: luck taken from internal 8-bit Fibonacci LFSR (taps 8,6,5,4), reset seed 8'hA5, advances every clk cycle, luck value = lfsr[W-1:0]; luck port present but ignored.
REQ-028 STAGE_LFSR_EN undefined: luck port used directly; no LFSR logic.

Verification (W=3, N=4, LOWMAX=2, TMO=15, macro undefined)
REQ-029 start, pass_in=1, bonus=0, luck=0, items 1,3,5,7 consecutive -> bad_cnt=0, pass_out=1, done two cycles after 4th item.
REQ-030 luck=1, items 1,4,3,6, bonus=2 -> bad_cnt=3 (2+1), pass_out=0; repeat bonus=3 -> pass_out=1.
REQ-031 items 2,0,5,7, pass_in=1, bonus=3 -> pass_out=0, timeout=0.
REQ-032 two items then item_valid=0 for 15 cycles -> timeout=1, pass_out=0, done pulse once, FSM back to IDLE.
REQ-033 rst asserted after 2nd item -> busy=0 immediately, no done; next stage evaluates from cleared state.
REQ-034 start re-pulsed during COLLECT -> ignored, result unchanged; pass_in=0 at start -> pass_out=0 despite bad_cnt=0.

Source files
------------

// File: rtl/stage_judge.sv
// stage_judge: collects N scored items per stage, weighs accidents and judges pass/fail.
// Optional STAGE_LFSR_EN: luck comes from an internal 8-bit LFSR instead of the luck port.
module stage_judge #(
  parameter int W = 3,
  parameter int N = 4,
  parameter int BW = 2,
  parameter int LOWMAX = 2,
  parameter int TMO = 15,
  parameter int CW = $clog2(2*N+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          pass_in,
  input  logic [BW-1:0] bonus_in,
  input  logic          item_valid,
  input  logic [W-1:0]  item,
  input  logic [W-1:0]  luck,
  output logic          busy,
  output logic          done,
  output logic          pass_out,
  output logic          timeout,
  output logic [CW-1:0] bad_cnt
);
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam int TW = $clog2(TMO+1);
  typedef enum logic [1:0] {IDLE, COLLECT, JUDGE, DONE} state_t;
  state_t        r_state;
  logic [KW-1:0] r_idx;
  logic [TW-1:0] r_idle;
  logic [CW-1:0] r_bad;
  logic [BW-1:0] r_bonus;
  logic          r_pass_lat, r_fail, r_pass, r_tmo;
  logic [W-1:0]  w_luck;
  logic [CW-1:0] w_add;
  logic [TW-1:0] w_idle_nxt;
  logic          w_last, w_ok;
`ifdef STAGE_LFSR_EN
  logic [7:0] r_lfsr;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_lfsr <= 8'hA5;
    else r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
  assign w_luck = r_lfsr[W-1:0];
`else
  assign w_luck = luck;
`endif
  // a missing item never counts as an accident; low-quality accidents weigh double
  assign w_add = (item != '0 && (item ^ w_luck) == W'(r_idx)) ? ((item <= W'(LOWMAX)) ? CW'(2) : CW'(1)) : '0;
  assign w_idle_nxt = r_idle + 1'b1;
  assign w_last = r_idx == KW'(N-1);
  assign w_ok = r_pass_lat & ~r_fail & ~r_tmo & (r_bad <= CW'(1) || {{CW{1'b0}}, r_bonus} >= {{BW{1'b0}}, r_bad});
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= IDLE;
      r_idx <= '0;
      r_idle <= '0;
      r_bad <= '0;
      r_bonus <= '0;
      r_pass_lat <= 1'b0;
      r_fail <= 1'b0;
      r_pass <= 1'b0;
      r_tmo <= 1'b0;
    end else
      case (r_state)
        IDLE:
          if (start) begin
            r_pass_lat <= pass_in;
            r_bonus <= bonus_in;
            r_idx <= '0;
            r_idle <= '0;
            r_bad <= '0;
            r_fail <= 1'b0;
            r_pass <= 1'b0;
            r_tmo <= 1'b0;
            r_state <= COLLECT;
          end
        COLLECT:
          if (item_valid) begin
            r_idle <= '0;
            r_fail <= r_fail | (item == '0);
            r_bad <= r_bad + w_add;
            r_idx <= w_last ? '0 : r_idx + 1'b1;
            r_state <= w_last ? JUDGE : COLLECT;
          end else begin
            r_idle <= w_idle_nxt;
            r_tmo <= w_idle_nxt == TW'(TMO);
            r_state <= (w_idle_nxt == TW'(TMO)) ? JUDGE : COLLECT;
          end
        JUDGE: begin
          r_pass <= w_ok;
          r_state <= DONE;
        end
        default: r_state <= IDLE;
      endcase
  assign busy = r_state != IDLE;
  assign done = r_state == DONE;
  assign pass_out = r_pass;
  assign timeout = r_tmo;
  assign bad_cnt = r_bad;
endmodule

// File: tb/tb_stage_judge.sv
// tb_stage_judge: directed stimulus with a scoreboard queue checked on each done pulse.
module tb_stage_judge;
  logic clk = 0, rst = 1, start = 0, pass_in = 0, item_valid = 0;
  logic [1:0] bonus_in = 0;
  logic [2:0] item = 0, luck = 0;
  logic busy, done, pass_out, timeout;
  logic [3:0] bad_cnt;
  int total = 0, bad = 0;
  logic [5:0] exp_q[$];
  logic [5:0] e;
  stage_judge dut (.clk(clk), .rst(rst), .start(start), .pass_in(pass_in), .bonus_in(bonus_in),
    .item_valid(item_valid), .item(item), .luck(luck), .busy(busy), .done(done),
    .pass_out(pass_out), .timeout(timeout), .bad_cnt(bad_cnt));
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [7:0] a, input logic [7:0] x);
    total++;
    if (a !== x) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", n, a, x);
    end
  endtask
  always @(negedge clk)
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done actual=1 required=0");
      end else begin
        e = exp_q.pop_front();
        chk("pass_out", 8'(pass_out), 8'(e[5]));
        chk("timeout", 8'(timeout), 8'(e[4]));
        chk("bad_cnt", 8'(bad_cnt), 8'(e[3:0]));
      end
    end
  task automatic wait_idle;
    for (int i = 0; i < 40 && busy; i++) @(negedge clk);
    chk("idle_bound", 8'(busy), 8'd0);
  endtask
  task automatic stage(input logic p, input logic [1:0] b, input logic [2:0] lk,
      input logic [2:0] i0, i1, i2, i3, input logic rs, input logic ep, input logic [3:0] eb);
    exp_q.push_back({ep, 1'b0, eb});
    @(posedge clk); #1; start = 1; pass_in = p; bonus_in = b; luck = lk; item_valid = 1; item = 0;
    @(posedge clk); #1; start = 0; pass_in = ~p; bonus_in = ~b; item = i0;
    @(posedge clk); #1; item = i1;
    @(posedge clk); #1; item = i2;
    if (rs) begin start = 1; pass_in = 0; bonus_in = 0; end
    @(posedge clk); #1; start = 0; item = i3;
    @(posedge clk); #1; item = 0;
    @(negedge clk); chk("lat_judge", 8'(done), 8'd0);
    @(negedge clk); chk("lat_done", 8'(done), 8'd1);
    @(posedge clk); #1; item_valid = 0;
    wait_idle();
  endtask
  initial begin
    #12;
    chk("rst_busy", 8'(busy), 8'd0);
    chk("rst_done", 8'(done), 8'd0);
    chk("rst_pass", 8'(pass_out), 8'd0);
    chk("rst_tmo", 8'(timeout), 8'd0);
    chk("rst_bad", 8'(bad_cnt), 8'd0);
    @(posedge clk); #1; rst = 0;
    stage(1, 0, 0, 1, 3, 5, 7, 0, 1, 0);
    stage(1, 2, 1, 1, 4, 3, 6, 0, 0, 3);
    stage(1, 3, 1, 1, 4, 3, 6, 0, 1, 3);
    stage(1, 3, 0, 2, 0, 5, 7, 0, 0, 0);
    stage(1, 3, 1, 1, 4, 3, 6, 1, 1, 3);
    stage(0, 3, 0, 1, 3, 5, 7, 0, 0, 0);
    // idle timeout after two items
    exp_q.push_back({1'b0, 1'b1, 4'd0});
    @(posedge clk); #1; start = 1; pass_in = 1; bonus_in = 3; luck = 0;
    @(posedge clk); #1; start = 0; item_valid = 1; item = 1;
    @(posedge clk); #1; item = 3;
    @(posedge clk); #1; item_valid = 0;
    repeat (14) @(posedge clk);
    @(negedge clk); chk("tmo_not_yet", 8'(timeout), 8'd0);
    @(negedge clk); chk("tmo_set", 8'(timeout), 8'd1);
    wait_idle();
    // reset mid-collect
    @(posedge clk); #1; start = 1; pass_in = 1; bonus_in = 0; luck = 1;
    @(posedge clk); #1; start = 0; item_valid = 1; item = 1;
    @(posedge clk); #1; item = 0;
    @(posedge clk); #1; rst = 1;
    #1; chk("rst_async_busy", 8'(busy), 8'd0);
    chk("rst_async_bad", 8'(bad_cnt), 8'd0);
    item_valid = 0;
    @(posedge clk); #1; rst = 0;
    stage(1, 0, 0, 1, 3, 5, 7, 0, 1, 0);
    repeat (3) @(posedge clk);
    chk("sb_empty", 8'(exp_q.size()), 8'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
